// File: rtl/jpeg_rle_symbol_enc.sv
// Streaming JPEG run-length symbol encoder.
// Takes zig-zag-ordered quantised coefficients one per beat. Produces
// (run, size, amplitude) tokens, plus ZRL and EOB markers, for the Huffman stage.
// The single-entry output register is loaded the cycle after a coefficient is accepted.
module jpeg_rle_symbol_enc #(
    parameter int COEF_W  = 12,
    parameter int BLK_LEN = 64,
    parameter int SIZE_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_run,
    output logic [SIZE_W-1:0] out_size,
    output logic [COEF_W-1:0] out_amp,
    output logic              out_dc,
    output logic              out_zrl,
    output logic              out_eob,
    output logic              out_last,
    output logic              err_len
);

    localparam int POS_W = $clog2(BLK_LEN);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(BLK_LEN - 1);

    typedef enum logic [1:0] {S_DC, S_AC, S_FLUSH} state_t;

    typedef struct packed {
        logic [3:0]        run;
        logic [SIZE_W-1:0] size;
        logic [COEF_W-1:0] amp;
        logic              dc;
        logic              zrl;
        logic              eob;
        logic              last;
    } tok_t;

    function automatic tok_t mkTok(input logic [3:0] run, input logic [SIZE_W-1:0] size,
                                   input logic [COEF_W-1:0] amp, input logic dc,
                                   input logic zrl, input logic eob, input logic last);
        tok_t t;
        t.run  = run;
        t.size = size;
        t.amp  = amp;
        t.dc   = dc;
        t.zrl  = zrl;
        t.eob  = eob;
        t.last = last;
        return t;
    endfunction

    state_t            state_q;
    logic [POS_W-1:0]  pos_q;
    logic [3:0]        run_q;
    logic [1:0]        zrlCnt_q;
    tok_t              hold_q;
    tok_t              out_q;
    logic              outValid_q;
    logic              errLen_q;

    logic              inFire;
    logic              outFire;
    logic              coefZero;
    logic              blkEnd;
    logic              lenErr;
    logic [COEF_W-1:0] coefMag;
    logic [COEF_W-1:0] coefAmpRaw;
    logic [COEF_W-1:0] coefAmp;
    logic [COEF_W-1:0] ampMask;
    logic [COEF_W-1:0] one;
    logic [SIZE_W-1:0] coefSize;
    tok_t              zrlTok;
    tok_t              eobTok;

    assign in_ready = !rst && (state_q != S_FLUSH) && (!outValid_q || out_ready);
    assign inFire   = in_valid && in_ready;
    assign outFire  = outValid_q && out_ready;
    assign coefZero = (in_coef == '0);
    assign blkEnd   = in_last || (pos_q == LAST_POS);
    assign lenErr   = (in_last && (pos_q != LAST_POS)) || (!in_last && (pos_q == LAST_POS));
    assign zrlTok   = mkTok(4'd15, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    assign eobTok   = mkTok(4'd0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    assign one      = COEF_W'(1);

    // Size category and amplitude bits of the incoming coefficient; the most
    // negative value has a magnitude that wraps to the MSB alone, giving size COEF_W.
    always_comb begin
        coefMag    = in_coef[COEF_W-1] ? (~in_coef + one) : in_coef;
        coefSize   = '0;
        for (int i = 0; i < COEF_W; i++) begin
            if (coefMag[i]) coefSize = SIZE_W'(i + 1);
        end
        coefAmpRaw = in_coef[COEF_W-1] ? (in_coef - one) : in_coef;
        ampMask    = (one << coefSize) - one;
        coefAmp    = coefAmpRaw & ampMask;
    end

    // Encoder state machine: tracks block position and zero runs, and loads the output token register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_DC;
            pos_q      <= '0;
            run_q      <= '0;
            zrlCnt_q   <= '0;
            hold_q     <= '0;
            out_q      <= '0;
            outValid_q <= 1'b0;
            errLen_q   <= 1'b0;
        end else begin
            errLen_q <= 1'b0;
            if (outFire) outValid_q <= 1'b0;
            case (state_q)
                S_DC: begin
                    if (inFire) begin
                        out_q      <= mkTok(4'd0, coefSize, coefAmp, 1'b1, 1'b0, 1'b0, blkEnd);
                        outValid_q <= 1'b1;
                        errLen_q   <= lenErr;
                        pos_q      <= blkEnd ? '0 : POS_W'(1);
                        run_q      <= '0;
                        zrlCnt_q   <= '0;
                        state_q    <= blkEnd ? S_DC : S_AC;
                    end
                end
                S_AC: begin
                    if (inFire) begin
                        errLen_q <= lenErr;
                        if (blkEnd) begin
                            pos_q <= '0;
                            run_q <= '0;
                            if (coefZero) begin
                                out_q      <= eobTok;
                                outValid_q <= 1'b1;
                                zrlCnt_q   <= '0;
                                state_q    <= S_DC;
                            end else if (zrlCnt_q != 2'd0) begin
                                out_q      <= zrlTok;
                                outValid_q <= 1'b1;
                                hold_q     <= mkTok(run_q, coefSize, coefAmp, 1'b0, 1'b0, 1'b0, 1'b1);
                                zrlCnt_q   <= zrlCnt_q - 2'd1;
                                state_q    <= S_FLUSH;
                            end else begin
                                out_q      <= mkTok(run_q, coefSize, coefAmp, 1'b0, 1'b0, 1'b0, 1'b1);
                                outValid_q <= 1'b1;
                                state_q    <= S_DC;
                            end
                        end else begin
                            pos_q <= pos_q + 1'b1;
                            if (coefZero) begin
                                if (run_q == 4'd15) begin
                                    run_q <= '0;
                                    if (zrlCnt_q != 2'd3) zrlCnt_q <= zrlCnt_q + 2'd1;
                                end else begin
                                    run_q <= run_q + 4'd1;
                                end
                            end else if (zrlCnt_q != 2'd0) begin
                                out_q      <= zrlTok;
                                outValid_q <= 1'b1;
                                hold_q     <= mkTok(run_q, coefSize, coefAmp, 1'b0, 1'b0, 1'b0, 1'b0);
                                zrlCnt_q   <= zrlCnt_q - 2'd1;
                                run_q      <= '0;
                                state_q    <= S_FLUSH;
                            end else begin
                                out_q      <= mkTok(run_q, coefSize, coefAmp, 1'b0, 1'b0, 1'b0, 1'b0);
                                outValid_q <= 1'b1;
                                run_q      <= '0;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (outFire) begin
                        outValid_q <= 1'b1;
                        if (zrlCnt_q != 2'd0) begin
                            out_q    <= zrlTok;
                            zrlCnt_q <= zrlCnt_q - 2'd1;
                        end else begin
                            out_q   <= hold_q;
                            state_q <= hold_q.last ? S_DC : S_AC;
                        end
                    end
                end
                default: state_q <= S_DC;
            endcase
        end
    end

    assign out_valid = outValid_q;
    assign out_run   = out_q.run;
    assign out_size  = out_q.size;
    assign out_amp   = out_q.amp;
    assign out_dc    = out_q.dc;
    assign out_zrl   = out_q.zrl;
    assign out_eob   = out_q.eob;
    assign out_last  = out_q.last;
    assign err_len   = errLen_q;

endmodule

// File: tb/tb_jpeg_rle_symbol_enc.sv
// Directed testbench for jpeg_rle_symbol_enc: hand-computed token streams per block.
module tb_jpeg_rle_symbol_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_coef;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_run;
    logic [3:0]  out_size;
    logic [11:0] out_amp;
    logic        out_dc;
    logic        out_zrl;
    logic        out_eob;
    logic        out_last;
    logic        err_len;

    int vectors = 0;
    int miscompares = 0;
    int errPulses = 0;
    int errBefore;
    logic [23:0] got[$];
    logic [23:0] exp[$];

    jpeg_rle_symbol_enc #(.COEF_W(12), .BLK_LEN(64), .SIZE_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_run(out_run), .out_size(out_size), .out_amp(out_amp),
        .out_dc(out_dc), .out_zrl(out_zrl), .out_eob(out_eob), .out_last(out_last),
        .err_len(err_len)
    );

    always #5 clk = ~clk;

    // Record every token transfer and every cycle of err_len, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready)
                got.push_back({out_dc, out_zrl, out_eob, out_last, out_run, out_size, out_amp});
            if (err_len) errPulses++;
        end
    end

    function automatic logic [23:0] tok(input bit dc, input bit zrl, input bit eob, input bit last,
                                        input int run, input int size, input int amp);
        return {dc, zrl, eob, last, 4'(run), 4'(size), 12'(amp)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Present one coefficient and wait (bounded) until it is accepted.
    task automatic applyStimulus(input int c, input bit last);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_coef  = 12'(c);
        in_last  = last;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("inReadyTimeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send positions from..to of a block: DC value, one nonzero AC, in_last at lastPos (-1 = never).
    task automatic sendRange(input int from, input int to, input int dcv, input int nzPos,
                             input int nzVal, input int lastPos);
        for (int p = from; p <= to; p++)
            applyStimulus((p == 0) ? dcv : ((p == nzPos) ? nzVal : 0), p == lastPos);
    endtask

    task automatic checkTokens(input string tag);
        repeat (8) @(negedge clk);
        #1;
        checkOutput({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            checkOutput($sformatf("%s_tok%0d", tag, i), 32'(got[i]), 32'(exp[i]));
        got.delete();
        exp.delete();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_coef = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstInReady", 32'(in_ready), 32'd0);
        checkOutput("rstOutLast", 32'(out_last), 32'd0);
        checkOutput("rstErrLen", 32'(err_len), 32'd0);
        rst = 1'b0;

        // Test 1: DC=5, all AC zero
        errBefore = errPulses;
        exp.push_back(tok(1, 0, 0, 0, 0, 3, 5));
        exp.push_back(tok(0, 0, 1, 1, 0, 0, 0));
        sendRange(0, 63, 5, -1, 0, 63);
        checkTokens("t1");
        checkOutput("t1Err", 32'(errPulses - errBefore), 32'd0);

        // Test 2: DC=-3, AC[20]=1, in_ready low while flushing the ZRL
        exp.push_back(tok(1, 0, 0, 0, 0, 2, 0));
        exp.push_back(tok(0, 1, 0, 0, 15, 0, 0));
        exp.push_back(tok(0, 0, 0, 0, 3, 1, 1));
        exp.push_back(tok(0, 0, 1, 1, 0, 0, 0));
        sendRange(0, 20, -3, 20, 1, 63);
        @(negedge clk);
        checkOutput("t2FlushReady", 32'(in_ready), 32'd0);
        sendRange(21, 63, -3, 20, 1, 63);
        checkTokens("t2");

        // Test 3: DC=0, AC[63]=-1
        exp.push_back(tok(1, 0, 0, 0, 0, 0, 0));
        repeat (3) exp.push_back(tok(0, 1, 0, 0, 15, 0, 0));
        exp.push_back(tok(0, 0, 0, 1, 14, 1, 0));
        sendRange(0, 63, 0, 63, -1, 63);
        checkTokens("t3");

        // Test 4: backpressure for 5 cycles with the AC[1] token pending
        exp.push_back(tok(1, 0, 0, 0, 0, 7, 100));
        exp.push_back(tok(0, 0, 0, 0, 0, 3, 0));
        exp.push_back(tok(0, 0, 0, 0, 1, 12, 12'h7FF));
        exp.push_back(tok(0, 0, 1, 1, 0, 0, 0));
        sendRange(0, 1, 100, 1, -7, 63);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("t4HoldValid", 32'(out_valid), 32'd1);
            checkOutput("t4HoldSize", 32'(out_size), 32'd3);
            checkOutput("t4HoldRun", 32'(out_run), 32'd0);
            checkOutput("t4HoldReady", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        sendRange(2, 63, 100, 3, -2048, 63);
        checkTokens("t4");

        // Test 5: early in_last at position 10, then a full block starting with DC=-1
        errBefore = errPulses;
        exp.push_back(tok(1, 0, 0, 0, 0, 4, 9));
        exp.push_back(tok(0, 0, 1, 1, 0, 0, 0));
        exp.push_back(tok(1, 0, 0, 0, 0, 1, 0));
        exp.push_back(tok(0, 0, 1, 1, 0, 0, 0));
        sendRange(0, 10, 9, -1, 0, 10);
        sendRange(0, 63, -1, -1, 0, 63);
        checkTokens("t5");
        checkOutput("t5Err", 32'(errPulses - errBefore), 32'd1);

        // Position 63 reached without in_last: block closes with an error pulse
        errBefore = errPulses;
        exp.push_back(tok(1, 0, 0, 0, 0, 1, 1));
        repeat (3) exp.push_back(tok(0, 1, 0, 0, 15, 0, 0));
        exp.push_back(tok(0, 0, 0, 1, 14, 2, 3));
        sendRange(0, 63, 1, 63, 3, -1);
        checkTokens("t7");
        checkOutput("t7Err", 32'(errPulses - errBefore), 32'd1);

        // Test 6: reset while flushing with ZRLs pending
        exp.push_back(tok(1, 0, 0, 0, 0, 0, 0));
        sendRange(0, 48, 0, -1, 0, -1);
        out_ready = 1'b0;
        sendRange(49, 49, 0, 49, 5, -1);
        @(negedge clk);
        checkOutput("t6PreZrl", 32'(out_zrl), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6RstValid", 32'(out_valid), 32'd0);
        checkOutput("t6RstZrl", 32'(out_zrl), 32'd0);
        checkOutput("t6RstReady", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        checkTokens("t6pre");
        exp.push_back(tok(1, 0, 0, 0, 0, 3, 7));
        exp.push_back(tok(0, 0, 1, 1, 0, 0, 0));
        sendRange(0, 63, 7, -1, 0, 63);
        checkTokens("t6post");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
